// File: rtl/x_stage_ctrl_if.sv
// x_stage_ctrl_if: execute-stage control bus between the pipeline latches, the multdiv unit and x_stage_ctrl
// Signals:
//   dx_ir/dx_pc/dx_regA/dx_regB/dx_dataA/dx_dataB  D/X latch contents
//   xm_rd/xm_we/xm_data, mw_rd/mw_we/mw_data      later-stage destinations for bypassing
//   flush                                          taken-branch kill of the instruction in X
//   md_ready/md_result                             multdiv completion strobe and result
//   opA/opB                                        resolved ALU operands
//   md_start/md_mul/md_div/md_opA/md_opB           multdiv launch pulse, op select, held operands
//   dx_en/bubble                                   pipeline advance enable and X/M nop insertion
//   res_valid/res_data/md_exc                      multdiv result strobe, value, timeout flag
// Modports: master drives the pipeline/multdiv side, slave is the controller.
interface x_stage_ctrl_if;
    logic [31:0] dx_ir;
    logic [11:0] dx_pc;
    logic [4:0]  dx_regA;
    logic [4:0]  dx_regB;
    logic [31:0] dx_dataA;
    logic [31:0] dx_dataB;
    logic [4:0]  xm_rd;
    logic        xm_we;
    logic [31:0] xm_data;
    logic [4:0]  mw_rd;
    logic        mw_we;
    logic [31:0] mw_data;
    logic        flush;
    logic        md_ready;
    logic [31:0] md_result;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        md_start;
    logic        md_mul;
    logic        md_div;
    logic [31:0] md_opA;
    logic [31:0] md_opB;
    logic        dx_en;
    logic        bubble;
    logic        res_valid;
    logic [31:0] res_data;
    logic        md_exc;

    modport master (
        output dx_ir, dx_pc, dx_regA, dx_regB, dx_dataA, dx_dataB,
               xm_rd, xm_we, xm_data, mw_rd, mw_we, mw_data,
               flush, md_ready, md_result,
        input  opA, opB, md_start, md_mul, md_div, md_opA, md_opB,
               dx_en, bubble, res_valid, res_data, md_exc
    );

    modport slave (
        input  dx_ir, dx_pc, dx_regA, dx_regB, dx_dataA, dx_dataB,
               xm_rd, xm_we, xm_data, mw_rd, mw_we, mw_data,
               flush, md_ready, md_result,
        output opA, opB, md_start, md_mul, md_div, md_opA, md_opB,
               dx_en, bubble, res_valid, res_data, md_exc
    );
endinterface

// File: rtl/x_stage_ctrl.sv
// x_stage_ctrl: execute-stage operand bypassing and multdiv stall/handshake control
// Ports:
//   clk  rising-edge clock shared with the D/X latch
//   clr  asynchronous active-low clear
//   bus  x_stage_ctrl_if.slave (pipeline latches, multdiv handshake, stall controls)
// Configuration: define X_BYPASS_EN to enable X/M and M/W operand forwarding;
// without it opA/opB pass the register-file operands straight through.
module x_stage_ctrl (
    input  logic          clk,
    input  logic          clr,
    x_stage_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t     state, state_nxt;
    logic [5:0] cnt;
    logic       is_mul, is_div, launch, timeout, finish;

    assign is_mul  = bus.dx_ir[31:27] == 5'b00000 && bus.dx_ir[6:2] == 5'b00110;
    assign is_div  = bus.dx_ir[31:27] == 5'b00000 && bus.dx_ir[6:2] == 5'b00111;
    assign launch  = (is_mul || is_div) && !bus.flush;
    // cnt holds completed WAIT cycles, so this cycle's increment reaches 63
    assign timeout = cnt == 6'd62;
    assign finish  = !bus.flush && (bus.md_ready || timeout);

`ifdef X_BYPASS_EN
    // X/M holds the younger result, so it takes priority over M/W
    assign bus.opA = (bus.xm_we && bus.xm_rd == bus.dx_regA && bus.dx_regA != 5'd0) ? bus.xm_data :
                     (bus.mw_we && bus.mw_rd == bus.dx_regA && bus.dx_regA != 5'd0) ? bus.mw_data :
                     bus.dx_dataA;
    assign bus.opB = (bus.xm_we && bus.xm_rd == bus.dx_regB && bus.dx_regB != 5'd0) ? bus.xm_data :
                     (bus.mw_we && bus.mw_rd == bus.dx_regB && bus.dx_regB != 5'd0) ? bus.mw_data :
                     bus.dx_dataB;
`else
    assign bus.opA = bus.dx_dataA;
    assign bus.opB = bus.dx_dataB;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.dx_en     = 1'b1;
        bus.bubble    = 1'b0;
        bus.md_start  = 1'b0;
        bus.res_valid = 1'b0;
        case (state)
            IDLE:  state_nxt = launch ? START : IDLE;
            START: begin
                bus.md_start = 1'b1;
                bus.dx_en    = 1'b0;
                bus.bubble   = 1'b1;
                state_nxt    = bus.flush ? IDLE : WAIT;
            end
            WAIT: begin
                bus.dx_en  = 1'b0;
                bus.bubble = 1'b1;
                state_nxt  = bus.flush ? IDLE : finish ? DONE : WAIT;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt          <= 6'd0;
            bus.md_opA   <= 32'd0;
            bus.md_opB   <= 32'd0;
            bus.md_mul   <= 1'b0;
            bus.md_div   <= 1'b0;
            bus.res_data <= 32'd0;
            bus.md_exc   <= 1'b0;
        end else begin
            cnt <= (state == WAIT) ? cnt + 6'd1 : 6'd0;
            if (state == IDLE && launch) begin
                bus.md_opA <= bus.opA;
                bus.md_opB <= bus.opB;
                bus.md_mul <= is_mul;
                bus.md_div <= is_div;
            end
            // a completion strobe coinciding with the timeout still delivers its result
            if (state == WAIT && finish) begin
                bus.res_data <= bus.md_ready ? bus.md_result : 32'd0;
                bus.md_exc   <= !bus.md_ready;
            end
        end
    end
endmodule

// File: doc/x_stage_ctrl.md
X_STAGE_CTRL -- requirements
Module: x_stage_ctrl

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock, shared with the D/X latch.
REQ-003 clr  in  1  asynchronous active-low clear.
REQ-004 dx_ir / dx_pc / dx_regA / dx_regB  in  32/12/5/5  D/X latch outputs: instruction, PC, source register numbers.
REQ-005 dx_dataA / dx_dataB  in  32/32  D/X latch register-file operands.
REQ-006 xm_rd, xm_we, xm_data  in  5/1/32  X/M destination, write enable, result.
REQ-007 mw_rd, mw_we, mw_data  in  5/1/32  M/W destination, write enable, writeback data.
REQ-008 flush  in  1  taken-branch kill of the instruction in X.
REQ-009 md_ready, md_result  in  1/32  multdiv completion strobe and result.
REQ-010 opA, opB  out  32/32  resolved ALU operands.
REQ-011 md_start, md_mul, md_div  out  1/1/1  multdiv launch pulse and operation select.
REQ-012 md_opA, md_opB  out  32/32  operands held stable for the multdiv.
REQ-013 dx_en  out  1  D/X latch (and upstream) enable; 0 means stall.
REQ-014 bubble  out  1  forces a nop into X/M this cycle.
REQ-015 res_valid, res_data, md_exc  out  1/32/1  multdiv result strobe, value, timeout flag.

Function
REQ-016 Decode SHALL use opcode dx_ir[31:27]=00000 (R-type) with ALU op dx_ir[6:2]=00110 (mul) or 00111 (div); all else is non-multdiv.
REQ-017 Forwarding SHALL select, per operand: xm_data if xm_we and xm_rd==reg and reg!=0; else mw_data if mw_we and mw_rd==reg and reg!=0; else dx_data; X/M wins over M/W.
REQ-018 FSM states SHALL be IDLE, START, WAIT, DONE.
REQ-019 IDLE: dx_en=1, bubble=0; on multdiv decode with flush=0, latch opA/opB into md_opA/md_opB and md_mul/md_div, go START.
REQ-020 START: md_start=1 for exactly this cycle, dx_en=0, bubble=1, counter cleared, md_ready ignored, go WAIT.
REQ-021 WAIT: dx_en=0, bubble=1, 6-bit counter increments each cycle; md_ready=1 captures md_result into res_data, go DONE.
REQ-022 Timeout: counter reaching 63 in WAIT without md_ready SHALL go DONE with res_data=0, md_exc=1; md_ready in the same cycle wins (md_exc=0).
REQ-023 DONE: res_valid=1 for one cycle, dx_en=1, bubble=0, go IDLE; res_data and md_exc hold until the next DONE.
REQ-024 flush in START or WAIT SHALL return to IDLE next cycle with no res_valid; flush in IDLE suppresses launch.
REQ-025 md_opA/md_opB SHALL remain constant from IDLE->START transition until leaving WAIT.
REQ-026 Non-multdiv instructions SHALL never stall; opA/opB are combinational with zero latency.

Reset
REQ-027 clr=0 SHALL immediately force IDLE, counter=0, md_opA=md_opB=res_data=0, md_mul=md_div=md_exc=res_valid=md_start=bubble=0, dx_en=1.
REQ-028 Reset asserted mid-WAIT SHALL abandon the operation; no res_valid after release.

Configuration
REQ-029 Macro X_BYPASS_EN defined: forwarding per REQ-017; undefined: opA=dx_dataA, opB=dx_dataB always, comparators absent; FSM unchanged.

Verification
REQ-030 add with dx_regA=3, xm_we=1, xm_rd=3, xm_data=0x55, mw_we=1, mw_rd=3, mw_data=0x77 -> opA=0x55 (X_BYPASS_EN) / dx_dataA without it.
REQ-031 dx_regB=0, xm_we=1, xm_rd=0, xm_data=0xFF, dx_dataB=0 -> opB=0.
REQ-032 mul 6x7, md_ready at 5th WAIT cycle with 42 -> md_start one pulse, dx_en=0 for 6 cycles, res_valid one cycle, res_data=42.
REQ-033 div, md_ready never -> DONE after 63 WAIT counts, md_exc=1, res_data=0.
REQ-034 flush in 3rd WAIT cycle -> IDLE next cycle, dx_en=1, no res_valid.
REQ-035 clr low during WAIT -> all outputs per REQ-027 asynchronously, IDLE after release.
